// File: rtl/dpwm_ctrl.sv
// dpwm_ctrl: prescaled digital PWM with IDLE/RUN/DRAIN sequencing and a double-buffered duty register
module dpwm_ctrl #(
    parameter int DUTY_MAX = 1000,
    parameter int STEP     = 10
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] div_sel,
    input  logic [9:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic [9:0] cuenta,
    output logic       pwm_out,
    output logic       period_end,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    localparam logic [9:0] DMAX = 10'(DUTY_MAX);
    localparam logic [9:0] STEP_W = 10'(STEP);
    state_t state_q, state_d;
    logic [2:0] presc_q, presc_d;
    logic [1:0] div_q, div_d;
    logic [9:0] cuenta_q, cuenta_d, active_q, active_d, pend_q, pend_d;
    logic pfull_q, pfull_d, pe_q, pe_d;
    logic running, tick, wrap, xfer, copy;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            div_q    <= '0;
            cuenta_q <= '0;
            active_q <= '0;
            pend_q   <= '0;
            pfull_q  <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            div_q    <= div_d;
            cuenta_q <= cuenta_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pfull_q  <= pfull_d;
            pe_q     <= pe_d;
        end
    end

    always_comb begin
        running = state_q == RUN || state_q == DRAIN;
        tick    = running && presc_q == 3'((4'd1 << div_q) - 4'd1);
        wrap    = tick && cuenta_q == DMAX;
        xfer    = duty_valid && !pfull_q;
        copy    = pfull_q && (state_q == IDLE || wrap);
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = enable ? RUN : IDLE;
            RUN:     state_d = enable ? RUN : DRAIN;
            DRAIN:   state_d = enable ? RUN : (wrap ? IDLE : DRAIN);
            default: state_d = IDLE;
        endcase
        presc_d  = (!running || tick) ? 3'd0 : presc_q + 3'd1;
        cuenta_d = !running ? 10'd0 : tick ? (wrap ? 10'd0 : cuenta_q + STEP_W) : cuenta_q;
        // div_sel is only sampled at period boundaries so a period never changes rate midway
        div_d    = ((state_q == IDLE && enable) || wrap) ? div_sel : div_q;
        pend_d   = xfer ? (duty_in > DMAX ? DMAX : duty_in) : pend_q;
        active_d = copy ? pend_q : active_q;
        pfull_d  = xfer | (pfull_q & ~copy);
        pe_d     = wrap;
    end

    assign duty_ready = !pfull_q;
    assign cuenta     = cuenta_q;
    assign pwm_out    = running && cuenta_q < active_q;
    assign period_end = pe_q;
    assign state      = state_q;
endmodule

// File: tb/tb_dpwm_ctrl.sv
// tb_dpwm_ctrl: directed plus random stimulus against a tick-index reference model
module tb_dpwm_ctrl;
    localparam int DUTY_MAX = 1000;
    localparam int STEP = 10;
    localparam int KMAX = DUTY_MAX / STEP;
    logic CLK = 0, reset = 0, enable = 0, duty_valid = 0;
    logic [1:0] div_sel = 0;
    logic [9:0] duty_in = 0;
    logic duty_ready, pwm_out, period_end;
    logic [9:0] cuenta;
    logic [1:0] state;
    int total = 0, bad = 0;
    int ms = 0, mk = 0, mcyc = 0, mdiv = 0, mact = 0;
    bit mpe = 0;
    int pq[$];

    dpwm_ctrl #(.DUTY_MAX(DUTY_MAX), .STEP(STEP)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .div_sel(div_sel), .duty_in(duty_in),
        .duty_valid(duty_valid), .duty_ready(duty_ready), .cuenta(cuenta), .pwm_out(pwm_out),
        .period_end(period_end), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit act_st;
        act_st = ms == 1 || ms == 2;
        chk("state", state, ms);
        chk("cuenta", cuenta, mk * STEP);
        chk("pwm_out", pwm_out, act_st && mk * STEP < mact);
        chk("period_end", period_end, mpe);
        chk("duty_ready", duty_ready, pq.size() == 0);
    endtask

    task automatic model_reset();
        ms = 0; mk = 0; mcyc = 0; mdiv = 0; mact = 0; mpe = 0;
        pq.delete();
    endtask

    // one CLK edge: tick when the cycle count within the tick reaches its 2^div length
    task automatic model_edge();
        bit run, tk, wr, xf;
        int nms;
        run = ms == 1 || ms == 2;
        tk  = run && mcyc == (1 << mdiv) - 1;
        wr  = tk && mk == KMAX;
        xf  = duty_valid && pq.size() == 0;
        if (pq.size() > 0 && (ms == 0 || wr)) mact = pq.pop_front();
        if (xf) pq.push_back(duty_in > DUTY_MAX ? DUTY_MAX : int'(duty_in));
        if ((ms == 0 && enable) || wr) mdiv = div_sel;
        mpe  = wr;
        mcyc = (!run || tk) ? 0 : mcyc + 1;
        mk   = !run ? 0 : wr ? 0 : tk ? mk + 1 : mk;
        if (ms == 0) nms = enable ? 1 : 0;
        else if (ms == 1) nms = enable ? 1 : 2;
        else nms = enable ? 1 : (wr ? 0 : 2);
        ms = nms;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_k(input int t);
        for (int i = 0; i < 4000 && mk != t; i++) step();
        if (mk != t) begin
            total++; bad++;
            $error("FAIL wait_k obs=%0d exp=%0d", mk, t);
        end
    endtask

    initial begin
        #12;
        model_reset();
        check_all();
        #1 reset = 1;
        duty_in = 10'd500; duty_valid = 1;
        step();
        duty_valid = 0;
        run(2);
        enable = 1; div_sel = 0;
        run(250);
        div_sel = 2;
        run(500);
        div_sel = 0;
        run(450);
        wait_k(40);
        duty_in = 10'd300; duty_valid = 1;
        step();
        duty_in = 10'd700;
        run(150);
        duty_valid = 0;
        duty_in = 10'd1023; duty_valid = 1;
        step();
        duty_valid = 0;
        run(250);
        duty_in = 10'd0; duty_valid = 1;
        step();
        duty_valid = 0;
        run(250);
        duty_in = 10'd500; duty_valid = 1;
        step();
        duty_valid = 0;
        wait_k(20);
        enable = 0;
        wait_k(60);
        enable = 1;
        run(100);
        enable = 0;
        run(250);
        enable = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) div_sel = 2'($urandom_range(0, 3));
            duty_valid = $urandom_range(0, 9) == 0;
            duty_in = 10'($urandom_range(0, 1023));
            step();
        end
        duty_valid = 0; enable = 1; div_sel = 0;
        wait_k(70);
        #2 reset = 0;
        #1;
        model_reset();
        check_all();
        @(posedge CLK); #1 check_all();
        #2 reset = 1;
        run(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
